mxm_operand_feeder: RTL and testbench

- Drives an MxM multiply-accumulate engine. Produces its A/X operand streams from two synchronous-read matrix memories and collects its per-dot-product Y results.
- Computes C = A(MxN) · X(NxP) by walking i, then j, then k, and issues one operand pair per cycle with no bubbles. The engine has no valid input, so operand timing must line up exactly with the engine's internal N-cycle period.
- Sits between the matrix buffers and the MxM engine, and owns the engine's synchronous active-high reset.

---
 rtl/mxm_operand_feeder.sv | 174 +++++++++++++++++
 tb/tb_mxm_operand_feeder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mxm_operand_feeder.sv
// Operand feeder for an MxM multiply-accumulate engine: streams A/X operands in
// i/j/k order from synchronous-read buffers and collects one result per dot product.
module mxm_operand_feeder #(
  parameter int unsigned W = 8,
  parameter int unsigned M = 4,
  parameter int unsigned N = 16,
  parameter int unsigned P = 4,
  localparam int unsigned AAW = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int unsigned XAW = (N * P > 1) ? $clog2(N * P) : 1,
  localparam int unsigned RW  = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned CW  = (P > 1) ? $clog2(P) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [AAW-1:0] a_addr,
  output logic           a_ren,
  input  logic [W-1:0]   a_rdata,
  output logic [XAW-1:0] x_addr,
  output logic           x_ren,
  input  logic [W-1:0]   x_rdata,
  output logic [W-1:0]   mxm_a,
  output logic [W-1:0]   mxm_x,
  output logic           mxm_rst,
  input  logic [W-1:0]   mxm_y,
  output logic           res_valid,
  output logic [W-1:0]   res_data,
  output logic [RW-1:0]  res_row,
  output logic [CW-1:0]  res_col
);

  localparam int unsigned KW = $clog2(N);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DRAIN} state_t;

  state_t         state, state_nx;
  logic [KW-1:0]  k, k_nx, eng_n;
  logic [CW-1:0]  j, j_nx, rj;
  logic [RW-1:0]  i, i_nx, ri;
  logic [AAW-1:0] a_base, a_base_nx, a_addr_nx;
  logic [XAW-1:0] x_addr_nx;
  logic           ren, ren_nx, feed_en, samp;
  logic           busy_nx, done_nx, mxm_rst_nx;
  logic           go, last_addr, last_el, last_res;

  assign go        = (state == IDLE) && start;
  assign last_addr = ren && (k == KW'(N - 1)) && (j == CW'(P - 1)) && (i == RW'(M - 1));
  // Engine count 0 while feeding means the final element of a dot product just landed.
  assign last_el   = feed_en && (eng_n == '0);
  assign last_res  = (ri == RW'(M - 1)) && (rj == CW'(P - 1));

  assign a_ren = ren;
  assign x_ren = ren;
  assign mxm_a = feed_en ? a_rdata : '0;
  assign mxm_x = feed_en ? x_rdata : '0;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = PRIME;
      PRIME:   state_nx = STREAM;
      STREAM:  if (last_addr) state_nx = DRAIN;
      DRAIN:   if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output and address-walk next values; addresses advance incrementally
  always_comb begin
    k_nx       = k;
    j_nx       = j;
    i_nx       = i;
    a_base_nx  = a_base;
    a_addr_nx  = a_addr;
    x_addr_nx  = x_addr;
    ren_nx     = ren;
    busy_nx    = (state_nx != IDLE);
    done_nx    = samp && last_res;
    mxm_rst_nx = !(go || ren);
    if (go) begin
      k_nx      = '0;
      j_nx      = '0;
      i_nx      = '0;
      a_base_nx = '0;
      a_addr_nx = '0;
      x_addr_nx = '0;
      ren_nx    = 1'b1;
    end else if (ren) begin
      if (last_addr) begin
        ren_nx = 1'b0;
      end else if (k != KW'(N - 1)) begin
        k_nx      = k + KW'(1);
        a_addr_nx = a_addr + AAW'(1);
        x_addr_nx = x_addr + XAW'(P);
      end else if (j != CW'(P - 1)) begin
        k_nx      = '0;
        j_nx      = j + CW'(1);
        a_addr_nx = a_base;
        x_addr_nx = XAW'(j) + XAW'(1);
      end else begin
        k_nx      = '0;
        j_nx      = '0;
        i_nx      = i + RW'(1);
        a_base_nx = a_base + AAW'(N);
        a_addr_nx = a_base + AAW'(N);
        x_addr_nx = '0;
      end
    end
  end

  // Registered outputs, engine-count mirror and result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mxm_rst   <= 1'b1;
      ren       <= 1'b0;
      feed_en   <= 1'b0;
      samp      <= 1'b0;
      k         <= '0;
      j         <= '0;
      i         <= '0;
      a_base    <= '0;
      a_addr    <= '0;
      x_addr    <= '0;
      eng_n     <= '0;
      ri        <= '0;
      rj        <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_row   <= '0;
      res_col   <= '0;
    end else begin
      busy      <= busy_nx;
      done      <= done_nx;
      mxm_rst   <= mxm_rst_nx;
      ren       <= ren_nx;
      feed_en   <= ren;
      samp      <= last_el;
      k         <= k_nx;
      j         <= j_nx;
      i         <= i_nx;
      a_base    <= a_base_nx;
      a_addr    <= a_addr_nx;
      x_addr    <= x_addr_nx;
      eng_n     <= (mxm_rst || (eng_n == KW'(N - 1))) ? '0 : eng_n + KW'(1);
      res_valid <= samp;
      if (go) begin
        ri <= '0;
        rj <= '0;
      end else if (samp) begin
        res_data <= mxm_y;
        res_row  <= ri;
        res_col  <= rj;
        if (rj == CW'(P - 1)) begin
          rj <= '0;
          ri <= ri + RW'(1);
        end else begin
          rj <= rj + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mxm_operand_feeder.sv
// Bench for mxm_operand_feeder: two configurations, each with a behavioural engine and
// synchronous-read memories; results checked against tables and a matrix-product model.
`timescale 1ns/1ps
module tb_mxm_operand_feeder;
  localparam int unsigned W  = 8;
  localparam int unsigned M1 = 2, N1 = 3, P1 = 2, T1 = 16;
  localparam int unsigned M2 = 4, N2 = 4, P2 = 4, T2 = 72;
  localparam int MPN1 = M1 * N1 * P1;
  localparam int MPN2 = M2 * N2 * P2;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Configuration 1: M=2 N=3 P=2
  logic start1, busy1, done1, a_ren1, x_ren1, mxm_rst1, res_valid1;
  logic [2:0] a_addr1, x_addr1;
  logic [W-1:0] a_rdata1 = '0, x_rdata1 = '0, mxm_y1 = '0, mxm_a1, mxm_x1, res_data1;
  logic [0:0] res_row1, res_col1;
  logic [W-1:0] amem1 [M1*N1];
  logic [W-1:0] xmem1 [N1*P1];

  mxm_operand_feeder #(.W(W), .M(M1), .N(N1), .P(P1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .a_addr(a_addr1), .a_ren(a_ren1), .a_rdata(a_rdata1),
    .x_addr(x_addr1), .x_ren(x_ren1), .x_rdata(x_rdata1),
    .mxm_a(mxm_a1), .mxm_x(mxm_x1), .mxm_rst(mxm_rst1), .mxm_y(mxm_y1),
    .res_valid(res_valid1), .res_data(res_data1), .res_row(res_row1), .res_col(res_col1));

  // Configuration 2: M=N=P=4
  logic start2, busy2, done2, a_ren2, x_ren2, mxm_rst2, res_valid2;
  logic [3:0] a_addr2, x_addr2;
  logic [W-1:0] a_rdata2 = '0, x_rdata2 = '0, mxm_y2 = '0, mxm_a2, mxm_x2, res_data2;
  logic [1:0] res_row2, res_col2;
  logic [W-1:0] amem2 [M2*N2];
  logic [W-1:0] xmem2 [N2*P2];

  mxm_operand_feeder #(.W(W), .M(M2), .N(N2), .P(P2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .a_addr(a_addr2), .a_ren(a_ren2), .a_rdata(a_rdata2),
    .x_addr(x_addr2), .x_ren(x_ren2), .x_rdata(x_rdata2),
    .mxm_a(mxm_a2), .mxm_x(mxm_x2), .mxm_rst(mxm_rst2), .mxm_y(mxm_y2),
    .res_valid(res_valid2), .res_data(res_data2), .res_row(res_row2), .res_col(res_col2));

  // Synchronous-read memories
  always @(posedge clk) begin
    if (a_ren1) a_rdata1 <= amem1[a_addr1];
    if (x_ren1) x_rdata1 <= xmem1[x_addr1];
    if (a_ren2) a_rdata2 <= amem2[a_addr2];
    if (x_ren2) x_rdata2 <= xmem2[x_addr2];
  end

  // Engine models: N-cycle period, element k lands on count (k+1) mod N, result registered
  int n1 = 0, n2 = 0;
  logic [W-1:0] acc1 = '0, acc2 = '0;
  always @(posedge clk) begin
    if (mxm_rst1) begin
      n1 <= 0; acc1 <= '0;
    end else begin
      n1 <= (n1 == N1 - 1) ? 0 : n1 + 1;
      if (n1 == 0) mxm_y1 <= W'(acc1 + mxm_a1 * mxm_x1);
      acc1 <= (n1 == 1) ? W'(mxm_a1 * mxm_x1) : W'(acc1 + mxm_a1 * mxm_x1);
    end
    if (mxm_rst2) begin
      n2 <= 0; acc2 <= '0;
    end else begin
      n2 <= (n2 == N2 - 1) ? 0 : n2 + 1;
      if (n2 == 0) mxm_y2 <= W'(acc2 + mxm_a2 * mxm_x2);
      acc2 <= (n2 == 1) ? W'(mxm_a2 * mxm_x2) : W'(acc2 + mxm_a2 * mxm_x2);
    end
  end

  // Monitor 1: per-cycle trace relative to the start cycle
  int s1 = 0, o1, rv_cnt1 = 0, dn_cnt1 = 0;
  bit rec1 = 1'b0;
  int tr_rst1[T1], tr_ren1[T1], tr_a1[T1], tr_x1[T1], tr_busy1[T1];
  int tr_done1[T1], tr_rv1[T1], tr_rd1[T1], tr_rr1[T1], tr_rc1[T1];
  always @(negedge clk) begin
    rv_cnt1 += int'(res_valid1);
    dn_cnt1 += int'(done1);
    if (rec1) begin
      o1 = cyc - s1;
      if (o1 >= 0 && o1 < T1) begin
        tr_rst1[o1] = int'(mxm_rst1);  tr_ren1[o1] = int'(a_ren1 & x_ren1);
        tr_a1[o1] = int'(a_addr1);     tr_x1[o1] = int'(x_addr1);
        tr_busy1[o1] = int'(busy1);    tr_done1[o1] = int'(done1);
        tr_rv1[o1] = int'(res_valid1); tr_rd1[o1] = int'(res_data1);
        tr_rr1[o1] = int'(res_row1);   tr_rc1[o1] = int'(res_col1);
      end
    end
  end

  // Monitor 2: result queue and address-stream audit
  typedef struct { int off; int row; int col; int data; } res_t;
  res_t rq2[$];
  int s2 = 0, o2, d2, k2, aq_n2 = 0, aq_bad2 = 0, done_n2 = 0, done_off2 = -1;
  bit rec2 = 1'b0;
  always @(negedge clk) begin
    if (rec2) begin
      o2 = cyc - s2;
      if (res_valid2) rq2.push_back('{o2, int'(res_row2), int'(res_col2), int'(res_data2)});
      if (done2) begin done_n2++; done_off2 = o2; end
      if (a_ren2) begin
        d2 = aq_n2 / N2;
        k2 = aq_n2 % N2;
        if (o2 != 1 + aq_n2 || int'(a_addr2) != (d2 / P2) * N2 + k2 ||
            int'(x_addr2) != k2 * P2 + d2 % P2 || !x_ren2)
          aq_bad2++;
        aq_n2++;
      end
    end
  end

  typedef struct { int a[6]; int x[6]; int c[4]; } vec1_t;
  vec1_t vt[4];

  // Starts a run in the current cycle and returns in the cycle after done.
  task automatic run1(input int v);
    int nrv, nd, bad_rst, bad_busy, bad_ren, bad_addr, o;
    for (int e = 0; e < 6; e++) begin
      amem1[e] = W'(vt[v].a[e]);
      xmem1[e] = W'(vt[v].x[e]);
    end
    s1 = cyc; rec1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (T1 - 1) @(posedge clk);
    #1 rec1 = 1'b0;
    nrv = 0; nd = 0; bad_rst = 0; bad_busy = 0; bad_ren = 0; bad_addr = 0;
    for (int t = 0; t < T1; t++) begin
      nrv += tr_rv1[t];
      nd  += tr_done1[t];
      bad_rst  += int'(tr_rst1[t]  != ((t >= 1 && t <= MPN1 + 1) ? 0 : 1));
      bad_busy += int'(tr_busy1[t] != ((t >= 1 && t <= MPN1 + 3) ? 1 : 0));
      bad_ren  += int'(tr_ren1[t]  != ((t >= 1 && t <= MPN1) ? 1 : 0));
    end
    for (int d = 0; d < M1 * P1; d++)
      for (int k = 0; k < N1; k++) begin
        o = 1 + d * N1 + k;
        bad_addr += int'(tr_a1[o] != (d / P1) * N1 + k || tr_x1[o] != k * P1 + d % P1);
      end
    chk($sformatf("v%0d_mxm_rst_window", v), bad_rst, 0);
    chk($sformatf("v%0d_busy_window", v), bad_busy, 0);
    chk($sformatf("v%0d_ren_window", v), bad_ren, 0);
    chk($sformatf("v%0d_addr_trace", v), bad_addr, 0);
    for (int d = 0; d < M1 * P1; d++) begin
      o = 3 + (d + 1) * N1;
      chk($sformatf("v%0d_res_valid%0d", v, d), tr_rv1[o], 1);
      chk($sformatf("v%0d_res_data%0d", v, d), tr_rd1[o], vt[v].c[d]);
      chk($sformatf("v%0d_res_row%0d", v, d), tr_rr1[o], d / P1);
      chk($sformatf("v%0d_res_col%0d", v, d), tr_rc1[o], d % P1);
    end
    chk($sformatf("v%0d_res_count", v), nrv, M1 * P1);
    chk($sformatf("v%0d_done_at_end", v), tr_done1[3 + MPN1], 1);
    chk($sformatf("v%0d_done_count", v), nd, 1);
  endtask

  task automatic run2(input string tag, input int hold, input bit ident);
    int i, j, e;
    rq2.delete(); aq_n2 = 0; aq_bad2 = 0; done_n2 = 0; done_off2 = -1;
    s2 = cyc; rec2 = 1'b1; start2 = 1'b1;
    repeat (hold) begin @(posedge clk); #1; end
    start2 = 1'b0;
    repeat (T2 - hold) @(posedge clk);
    #1 rec2 = 1'b0;
    chk({tag, "_addr_count"}, aq_n2, MPN2);
    chk({tag, "_addr_stream"}, aq_bad2, 0);
    chk({tag, "_done_count"}, done_n2, 1);
    chk({tag, "_done_cycle"}, done_off2, 3 + MPN2);
    chk({tag, "_res_count"}, rq2.size(), M2 * P2);
    for (int d = 0; d < M2 * P2 && d < rq2.size(); d++) begin
      i = d / P2; j = d % P2; e = 0;
      if (ident) e = int'(xmem2[i * P2 + j]);
      else for (int k = 0; k < N2; k++)
        e = (e + int'(amem2[i * N2 + k]) * int'(xmem2[k * P2 + j])) % 256;
      chk($sformatf("%s_res_cycle%0d", tag, d), rq2[d].off, 3 + (d + 1) * N2);
      chk($sformatf("%s_res_rowcol%0d", tag, d), rq2[d].row * 16 + rq2[d].col, i * 16 + j);
      chk($sformatf("%s_res_data%0d", tag, d), rq2[d].data, e);
    end
  endtask

  int rv_snap, dn_snap;

  initial begin
    vt[0].a = '{1, 2, 3, 4, 5, 6};          vt[0].x = '{7, 8, 9, 10, 11, 12};
    vt[0].c = '{58, 64, 139, 154};
    vt[1].a = '{16, 16, 16, 16, 16, 16};    vt[1].x = '{16, 16, 16, 16, 16, 16};
    vt[1].c = '{0, 0, 0, 0};
    vt[2].a = '{1, 0, 2, 0, 1, 0};          vt[2].x = '{1, 2, 3, 4, 5, 6};
    vt[2].c = '{11, 14, 3, 4};
    vt[3].a = '{255, 255, 255, 255, 255, 255}; vt[3].x = '{255, 255, 255, 255, 255, 255};
    vt[3].c = '{3, 3, 3, 3};

    start1 = 1'b0; start2 = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mxm_rst", mxm_rst1, 1);
    chk("rst_ctrl", {busy1, done1, res_valid1, a_ren1, x_ren1}, 0);
    chk("rst_mxm_ops", {mxm_a1, mxm_x1}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Table vectors, each one started in the cycle after the previous done
    for (int v = 0; v < 4; v++) run1(v);

    // Reset in the middle of an operation
    repeat (2) @(posedge clk);
    #1;
    for (int e = 0; e < 6; e++) begin amem1[e] = W'(vt[0].a[e]); xmem1[e] = W'(vt[0].x[e]); end
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_mxm_rst", mxm_rst1, 1);
    chk("abort_ctrl", {busy1, done1, res_valid1, a_ren1, x_ren1}, 0);
    chk("abort_addr", {a_addr1, x_addr1}, 0);
    chk("abort_res", {res_data1, res_row1, res_col1}, 0);
    chk("abort_mxm_ops", {mxm_a1, mxm_x1}, 0);
    rv_snap = rv_cnt1; dn_snap = dn_cnt1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_res_valid", rv_cnt1 - rv_snap, 0);
    chk("abort_no_done", dn_cnt1 - dn_snap, 0);
    run1(0);

    // Identity A: result equals X, start held for 20 cycles
    for (int r = 0; r < N2; r++)
      for (int c = 0; c < N2; c++) amem2[r * N2 + c] = (r == c) ? W'(1) : W'(0);
    for (int e = 0; e < N2 * P2; e++) xmem2[e] = W'($urandom_range(255));
    run2("ident_hold", 20, 1'b1);

    // Random matrices against the product model
    for (int t = 0; t < 3; t++) begin
      for (int e = 0; e < M2 * N2; e++) amem2[e] = W'($urandom_range(255));
      for (int e = 0; e < N2 * P2; e++) xmem2[e] = W'($urandom_range(255));
      run2($sformatf("rand%0d", t), 1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
